timer_irq_ctrl: RTL and testbench

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

---
 rtl/timer_irq_ctrl.sv | 91 +++++++++
 tb/tb_timer_irq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_irq_ctrl
// Description : Timer event detection, sticky W1C status, IRQ and halt FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_irq_ctrl (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic [31:0] cnt,
    input  logic [31:0] last_cnt,
    input  logic        updown,
    input  logic        timer_en,
    input  logic [31:0] cmp_val,
    input  logic        mode,
    input  logic        auto_reload,
    input  logic [1:0]  int_en,
    input  logic        clr_wr,
    input  logic [1:0]  clr_data,
    output logic [1:0]  int_st,
    output logic        irq,
    output logic        load_req,
    output logic        cnt_halt,
    output logic [1:0]  state
);

    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] c_ZERO     = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_int_st;
    logic [1:0]  w_int_st_nxt;
    logic [1:0]  w_clr_mask;
    logic        r_load_req;
    logic        w_run;
    logic        w_match;
    logic        w_ovf;
    logic        w_unf;

    assign w_run = (r_state == S_RUN);

    // Only the cycle the counter enters the compare value is an event.
    assign w_match = w_run && (cnt == cmp_val) && (cnt != last_cnt);
    assign w_ovf   = w_run && !updown && (last_cnt == c_ALL_ONES) && (cnt == c_ZERO);
    assign w_unf   = w_run &&  updown && (last_cnt == c_ZERO) && (cnt == c_ALL_ONES);

    assign w_clr_mask   = clr_wr ? clr_data : 2'b00;
    // OR-ing the events in after the clear lets a same-cycle set win.
    assign w_int_st_nxt = (r_int_st & ~w_clr_mask) | {(w_ovf | w_unf), w_match};

    always_comb begin
        w_state_nxt = r_state;
        if (!timer_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_RUN;
                S_RUN:    if (w_match && mode) w_state_nxt = S_HALTED;
                S_HALTED: w_state_nxt = S_HALTED;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state    <= S_IDLE;
            r_int_st   <= 2'b00;
            r_load_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_int_st   <= w_int_st_nxt;
            r_load_req <= w_match && !mode && auto_reload;
        end
    end

    assign int_st   = r_int_st;
    assign irq      = |(r_int_st & int_en);
    assign load_req = r_load_req;
    assign cnt_halt = (r_state == S_HALTED);
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_irq_ctrl
// Description : Directed vector table, corner sequences and random vs. model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_irq_ctrl;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic [31:0] cnt;
    logic [31:0] last_cnt;
    logic        updown;
    logic        timer_en;
    logic [31:0] cmp_val;
    logic        mode;
    logic        auto_reload;
    logic [1:0]  int_en;
    logic        clr_wr;
    logic [1:0]  clr_data;
    logic [1:0]  int_st;
    logic        irq;
    logic        load_req;
    logic        cnt_halt;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    timer_irq_ctrl u_dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .cnt         (cnt),
        .last_cnt    (last_cnt),
        .updown      (updown),
        .timer_en    (timer_en),
        .cmp_val     (cmp_val),
        .mode        (mode),
        .auto_reload (auto_reload),
        .int_en      (int_en),
        .clr_wr      (clr_wr),
        .clr_data    (clr_data),
        .int_st      (int_st),
        .irq         (irq),
        .load_req    (load_req),
        .cnt_halt    (cnt_halt),
        .state       (state)
    );

    typedef struct {
        logic        rstn;
        logic        en;
        logic [31:0] c;
        logic [31:0] lc;
        logic        ud;
        logic [31:0] cmp;
        logic        md;
        logic        ar;
        logic [1:0]  ie;
        logic        cw;
        logic [1:0]  cd;
        logic [1:0]  x_st;
        logic [1:0]  x_state;
        logic        x_irq;
        logic        x_load;
        logic        x_halt;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        preset_n = v.rstn; timer_en = v.en; cnt = v.c; last_cnt = v.lc;
        updown = v.ud; cmp_val = v.cmp; mode = v.md; auto_reload = v.ar;
        int_en = v.ie; clr_wr = v.cw; clr_data = v.cd;
    endtask

    function automatic vec_t mk(input logic rstn, input logic en, input logic [31:0] c,
                                input logic [31:0] lc, input logic ud, input logic [31:0] cmp,
                                input logic md, input logic ar, input logic [1:0] ie,
                                input logic cw, input logic [1:0] cd, input logic [1:0] xs,
                                input logic [1:0] xstate, input logic xi, input logic xl,
                                input logic xh);
        vec_t v;
        v.rstn = rstn; v.en = en; v.c = c; v.lc = lc; v.ud = ud; v.cmp = cmp;
        v.md = md; v.ar = ar; v.ie = ie; v.cw = cw; v.cd = cd;
        v.x_st = xs; v.x_state = xstate; v.x_irq = xi; v.x_load = xl; v.x_halt = xh;
        return v;
    endfunction

    // Reference model: observable state as the 0/1/2 code seen on the state port.
    int          m_state;
    logic [1:0]  m_st;
    logic        m_load;

    task automatic model_edge();
        bit in_run, m, wrap;
        if (!preset_n) begin
            m_state = 0; m_st = 2'b00; m_load = 1'b0;
        end else begin
            in_run = (m_state == 1);
            m    = in_run && cnt == cmp_val && cnt != last_cnt;
            wrap = in_run && ((updown == 0 && last_cnt == 32'hFFFF_FFFF && cnt == 0) ||
                              (updown == 1 && last_cnt == 0 && cnt == 32'hFFFF_FFFF));
            if (clr_wr) m_st = m_st & ~clr_data;
            if (m)    m_st[0] = 1'b1;
            if (wrap) m_st[1] = 1'b1;
            m_load = m && mode == 0 && auto_reload == 1;
            if (!timer_en)                     m_state = 0;
            else if (m_state == 0)             m_state = 1;
            else if (m_state == 1 && m && mode) m_state = 2;
        end
    endtask

    initial begin
        // Columns: rstn en cnt last updown cmp mode ar int_en clr_wr clr_data | st state irq load halt
        vt[0]  = mk(0,0,0,0,0,5,0,0,2'b00,0,2'b00, 2'b00,2'd0,0,0,0);
        vt[1]  = mk(1,1,4,3,0,5,0,1,2'b01,0,2'b00, 2'b00,2'd1,0,0,0);
        vt[2]  = mk(1,1,5,4,0,5,0,1,2'b01,0,2'b00, 2'b01,2'd1,1,1,0);
        vt[3]  = mk(1,1,5,5,0,5,0,1,2'b01,0,2'b00, 2'b01,2'd1,1,0,0);
        vt[4]  = mk(1,1,6,5,0,5,0,1,2'b01,1,2'b01, 2'b00,2'd1,0,0,0);
        vt[5]  = mk(1,1,5,4,0,5,0,1,2'b01,0,2'b00, 2'b01,2'd1,1,1,0);
        vt[6]  = mk(1,1,5,4,0,5,0,1,2'b01,1,2'b01, 2'b01,2'd1,1,1,0);
        vt[7]  = mk(1,1,6,5,0,5,0,1,2'b01,1,2'b01, 2'b00,2'd1,0,0,0);
        vt[8]  = mk(1,1,0,32'hFFFF_FFFF,0,5,0,1,2'b10,0,2'b00, 2'b10,2'd1,1,0,0);
        vt[9]  = mk(1,1,1,0,0,5,0,1,2'b10,1,2'b10, 2'b00,2'd1,0,0,0);
        vt[10] = mk(1,1,32'hFFFF_FFFF,0,1,5,0,1,2'b10,0,2'b00, 2'b10,2'd1,1,0,0);
        vt[11] = mk(1,1,32'h10,32'hF,0,32'h10,1,0,2'b01,0,2'b00, 2'b11,2'd2,1,0,1);
        vt[12] = mk(1,1,32'h10,32'h10,0,32'h10,1,0,2'b01,0,2'b00, 2'b11,2'd2,1,0,1);
        vt[13] = mk(1,0,32'h10,32'h10,0,32'h10,1,0,2'b01,0,2'b00, 2'b11,2'd0,1,0,0);
        vt[14] = mk(1,1,32'h20,32'h1F,0,32'h10,1,0,2'b01,0,2'b00, 2'b11,2'd1,1,0,0);
        vt[15] = mk(1,1,32'h10,32'hF,0,32'h10,1,0,2'b01,0,2'b00, 2'b11,2'd2,1,0,1);
        vt[16] = mk(0,1,32'h10,32'hF,0,32'h10,1,0,2'b11,1,2'b00, 2'b00,2'd0,0,0,0);

        drive(vt[0]);
        repeat (2) @(posedge pclk);
        #1;
        for (int i = 0; i < 17; i++) begin
            drive(vt[i]);
            @(posedge pclk);
            #1;
            check($sformatf("vec%0d.int_st", i),   {30'd0, int_st}, {30'd0, vt[i].x_st});
            check($sformatf("vec%0d.state", i),    {30'd0, state},  {30'd0, vt[i].x_state});
            check($sformatf("vec%0d.irq", i),      {31'd0, irq},      {31'd0, vt[i].x_irq});
            check($sformatf("vec%0d.load_req", i), {31'd0, load_req}, {31'd0, vt[i].x_load});
            check($sformatf("vec%0d.cnt_halt", i), {31'd0, cnt_halt}, {31'd0, vt[i].x_halt});
        end

        // Masking is combinational: build int_st = 11, then vary int_en between edges.
        drive(mk(1,1,0,0,0,5,0,0,2'b01,0,2'b00, 0,0,0,0,0));
        @(posedge pclk); #1;
        cnt = 5; last_cnt = 4;
        @(posedge pclk); #1;
        cnt = 0; last_cnt = 32'hFFFF_FFFF;
        @(posedge pclk); #1;
        cnt = 1; last_cnt = 0;
        check("mask.int_st_11", {30'd0, int_st}, 32'd3);
        int_en = 2'b00; #1;
        check("mask.irq_en00", {31'd0, irq}, 32'd0);
        int_en = 2'b10; #1;
        check("mask.irq_en10", {31'd0, irq}, 32'd1);
        int_en = 2'b01; #1;
        check("mask.irq_en01", {31'd0, irq}, 32'd1);
        check("mask.int_st_kept", {30'd0, int_st}, 32'd3);

        // Randomized phase against the model, starting from a clean reset.
        preset_n = 1'b0;
        @(posedge pclk); #1;
        m_state = 0; m_st = 2'b00; m_load = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int kind;
            preset_n    = ($urandom_range(0, 99) != 0);
            timer_en    = ($urandom_range(0, 11) != 0);
            mode        = 1'($urandom_range(0, 1));
            auto_reload = 1'($urandom_range(0, 1));
            updown      = 1'($urandom_range(0, 1));
            int_en      = 2'($urandom_range(0, 3));
            clr_wr      = ($urandom_range(0, 5) == 0);
            clr_data    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cmp_val = 32'h0;
                1:       cmp_val = 32'hFFFF_FFFF;
                default: cmp_val = $urandom;
            endcase
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin last_cnt = cmp_val - 32'd1; cnt = cmp_val; end
                1: begin last_cnt = cmp_val; cnt = cmp_val; end
                2: begin last_cnt = 32'hFFFF_FFFF; cnt = 32'h0; end
                3: begin last_cnt = 32'h0; cnt = 32'hFFFF_FFFF; end
                4: begin last_cnt = $urandom; cnt = $urandom; end
                default: begin last_cnt = cmp_val ^ (32'h1 << $urandom_range(0, 31)); cnt = cmp_val; end
            endcase
            @(posedge pclk);
            model_edge();
            #1;
            check("rnd.int_st",   {30'd0, int_st},   {30'd0, m_st});
            check("rnd.state",    {30'd0, state},    m_state);
            check("rnd.load_req", {31'd0, load_req}, {31'd0, m_load});
            check("rnd.cnt_halt", {31'd0, cnt_halt}, {31'd0, (m_state == 2)});
            check("rnd.irq",      {31'd0, irq},      {31'd0, |(m_st & int_en)});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
